axis_frame_len_guard: RTL
=========================

// Module: axis_frame_len_guard
// PURPOSE
// - AXI-stream frame length guard, sits directly upstream of the frame-mode axis_fifo.
// - Counts bytes per frame, truncates frames longer than MAX_LEN, flags runts below MIN_LEN.
// - Flags are written into tuser so the downstream FIFO can drop bad frames (DROP_BAD_FRAME).
// - One registered output stage; throughput one beat per cycle.
// PARAMETERS
// DATA_WIDTH   8                  tdata width, multiple of 8
// KEEP_ENABLE  (DATA_WIDTH>8)     use tkeep for byte count; else every beat = KEEP_WIDTH bytes
// KEEP_WIDTH   (DATA_WIDTH/8)     tkeep width
// ID_WIDTH     8                  tid width, passed through
// DEST_WIDTH   8                  tdest width, passed through
// USER_WIDTH   1                  tuser width; bit 0 is the bad-frame bit
// LEN_WIDTH    16                 byte counter width, saturating
// MIN_LEN      4                  minimum good frame length in bytes
// MAX_LEN      1518               maximum frame length in bytes (MAX_LEN >= MIN_LEN >= 1)
// PORTS
// clk                input   1           clock
// rst                input   1           asynchronous reset, active-low
// s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser   AXI-stream slave, widths per params
// m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser   AXI-stream master, widths per params
// status_frame_len   output  LEN_WIDTH   byte count of frame just closed (saturated)
// status_frame_done  output  1           1-cycle pulse when input tlast beat (or truncation) accepted
// status_truncated   output  1           1-cycle pulse: frame exceeded MAX_LEN
// status_runt        output  1           1-cycle pulse: frame shorter than MIN_LEN
// BEHAVIOUR
// - Reset (rst=0, async): state=PASS, count=0, m_axis_tvalid=0, all m_axis_* data=0, all status=0.
//   Reset mid-frame discards the partial frame; first beat after release starts a new frame.
// - beat_bytes = popcount(tkeep) if KEEP_ENABLE else KEEP_WIDTH; cnt_next = count+beat_bytes,
//   saturating at 2^LEN_WIDTH-1. m_axis_tkeep = s_axis_tkeep when KEEP_ENABLE, else all ones.
// - Output register: latency 1 cycle. Load when s_axis_tvalid && s_axis_tready in PASS.
//   m_axis_tvalid clears on m_axis_tready with no new load; payload stable while valid && !ready.
// - s_axis_tready = (state==DROP) | !m_axis_tvalid | m_axis_tready (registered-output skid-free).
// - State PASS, accepted beat:
//   * cnt_next > MAX_LEN: output beat with tlast=1, tuser[0]=1; pulse truncated+frame_done,
//     status_frame_len=cnt_next; count=0; if input tlast=0 go DROP, else stay PASS.
//   * else tlast=1: output tuser[0] = s_tuser[0] | (cnt_next < MIN_LEN); pulse frame_done,
//     runt if cnt_next<MIN_LEN; status_frame_len=cnt_next; count=0.
//   * else: forward beat unchanged, count=cnt_next.
//   * tuser[USER_WIDTH-1:1] always passed through; tid/tdest/tdata passed through.
// - State DROP: s_axis_tready=1, beats accepted and discarded, nothing output, no count;
//   input tlast accepted -> PASS. Output register still drains normally while in DROP.
// - Status pulses fire on the input-acceptance cycle edge (registered, 1 cycle wide);
//   status_frame_len holds last value until next frame close.
// - Zero-byte beats (tkeep=0) accepted and forwarded; add 0 to count.
// TESTING
// 1 DW=8,MIN=4: bytes 1,2,3 tlast on 3, m_tready=1 -> out 1,2,3; beat3 tuser=1; runt pulse; len=3.
// 2 DW=8,MAX=4: bytes 1..6 tlast on 6 -> out 1..5, beat5 tlast=1 tuser=1; beat6 dropped; truncated.
// 3 backpressure: m_tready=0 3 cycles with full reg -> s_tready=0, m_tdata held; resumes, no loss.
// 4 s_tuser=1 on last beat of a 6-byte frame (MIN=4,MAX=8) -> out tuser=1, no runt/truncated pulse.
// 5 DW=32: tkeep 4'hF,4'hF,4'h3 tlast -> status_frame_len=10, tkeep passed through unchanged.
// 6 rst=0 mid-frame (after 2 beats) -> m_tvalid=0 at once; next frame 4 bytes counts len=4.

Source files
------------

// File: rtl/axis_frame_len_guard_if.sv
// AXI-stream bundle shared by the slave and master sides of the frame length guard.
interface axis_frame_len_guard_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_len_guard.sv
// Frame length guard: counts bytes per frame, truncates over-long frames, marks runts in tuser[0].
//
// state | meaning
// PASS  | forwarding beats through the output register and counting bytes
// DROP  | frame was truncated; swallowing input beats up to and including its tlast
module axis_frame_len_guard #(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int LEN_WIDTH   = 16,
    parameter int MIN_LEN     = 4,
    parameter int MAX_LEN     = 1518
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_frame_len_guard_if.slave  s_axis,
    axis_frame_len_guard_if.master m_axis,
    output logic [LEN_WIDTH-1:0] status_frame_len,
    output logic                 status_frame_done,
    output logic                 status_truncated,
    output logic                 status_runt
);
    localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;

    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [ID_WIDTH-1:0]   tid_q, tid_d;
    logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;

    logic [LEN_WIDTH-1:0]  len_d;
    logic                  done_d, trunc_d, runt_d;

    logic [LEN_WIDTH-1:0]  beat_bytes;
    logic [LEN_WIDTH:0]    sum;
    logic [LEN_WIDTH-1:0]  cnt_next;
    logic                  too_long, is_runt;
    logic                  s_ready, accept;

    always_comb begin
        beat_bytes = '0;
        if (KEEP_ENABLE) begin
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                beat_bytes = beat_bytes + LEN_WIDTH'(s_axis.tkeep[i]);
            end
        end else begin
            beat_bytes = LEN_WIDTH'(KEEP_WIDTH);
        end
    end

    // The carry out of the widened add saturates the count rather than wrapping.
    assign sum      = {1'b0, count_q} + {1'b0, beat_bytes};
    assign cnt_next = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
    assign too_long = (cnt_next > MAX_L);
    assign is_runt  = (cnt_next < MIN_L);

    assign s_ready       = (state_q == ST_DROP) || !tvalid_q || m_axis.tready;
    assign accept        = s_axis.tvalid && s_ready;
    assign s_axis.tready = s_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tvalid_d = tvalid_q && !m_axis.tready;
        tlast_d  = tlast_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;
        tuser_d  = tuser_q;
        len_d    = status_frame_len;
        done_d   = 1'b0;
        trunc_d  = 1'b0;
        runt_d   = 1'b0;

        if (accept) begin
            case (state_q)
                ST_PASS: begin
                    tvalid_d = 1'b1;
                    tdata_d  = s_axis.tdata;
                    tkeep_d  = KEEP_ENABLE ? s_axis.tkeep : '1;
                    tlast_d  = s_axis.tlast;
                    tid_d    = s_axis.tid;
                    tdest_d  = s_axis.tdest;
                    tuser_d  = s_axis.tuser;
                    if (too_long) begin
                        tlast_d    = 1'b1;
                        tuser_d[0] = 1'b1;
                        trunc_d    = 1'b1;
                        done_d     = 1'b1;
                        len_d      = cnt_next;
                        count_d    = '0;
                        if (!s_axis.tlast) begin
                            state_d = ST_DROP;
                        end
                    end else if (s_axis.tlast) begin
                        tuser_d[0] = s_axis.tuser[0] | is_runt;
                        done_d     = 1'b1;
                        runt_d     = is_runt;
                        len_d      = cnt_next;
                        count_d    = '0;
                    end else begin
                        count_d = cnt_next;
                    end
                end
                ST_DROP: begin
                    if (s_axis.tlast) begin
                        state_d = ST_PASS;
                    end
                end
                default: state_d = ST_PASS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= ST_PASS;
            count_q           <= '0;
            tdata_q           <= '0;
            tkeep_q           <= '0;
            tvalid_q          <= 1'b0;
            tlast_q           <= 1'b0;
            tid_q             <= '0;
            tdest_q           <= '0;
            tuser_q           <= '0;
            status_frame_len  <= '0;
            status_frame_done <= 1'b0;
            status_truncated  <= 1'b0;
            status_runt       <= 1'b0;
        end else begin
            state_q           <= state_d;
            count_q           <= count_d;
            tdata_q           <= tdata_d;
            tkeep_q           <= tkeep_d;
            tvalid_q          <= tvalid_d;
            tlast_q           <= tlast_d;
            tid_q             <= tid_d;
            tdest_q           <= tdest_d;
            tuser_q           <= tuser_d;
            status_frame_len  <= len_d;
            status_frame_done <= done_d;
            status_truncated  <= trunc_d;
            status_runt       <= runt_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tid    = tid_q;
    assign m_axis.tdest  = tdest_q;
    assign m_axis.tuser  = tuser_q;
endmodule
